line_arbiter_wb: RTL
====================

// Module: line_arbiter_wb
// PURPOSE
//  Two-master Wishbone arbiter feeding the cpu_wb slave port of the eviction write-back cache.
//  Master 0 = I-cache line port, master 1 = D-cache line port; one 128-bit line transaction at a time.
//  Round-robin grant; request registered to slave side, response registered back to owner.
// PARAMETERS
//  ADDR_W   12   line address width (byte address bits [15:4])
//  DATA_W   128  line data width
//  SEL_W    16   byte-select width, = DATA_W/8
//  TIMEOUT  255  watchdog limit in cycles (used only with LINE_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       synchronous, active-high reset
//  m{0,1}_cyc   in   1       master cycle valid
//  m{0,1}_stb   in   1       master strobe; held with cyc until ack/rty
//  m{0,1}_we    in   1       1 = line write, 0 = line read
//  m{0,1}_adr   in   ADDR_W  line address
//  m{0,1}_sel   in   SEL_W   byte enables
//  m{0,1}_dat_m in   DATA_W  write data from master
//  m{0,1}_dat_s out  DATA_W  read data to master, valid with m*_ack
//  m{0,1}_ack   out  1       one-cycle completion pulse
//  m{0,1}_rty   out  1       one-cycle retry pulse
//  s_cyc/s_stb  out  1       slave-side cycle/strobe to eviction cache
//  s_we         out  1       registered copy of owner we
//  s_adr        out  ADDR_W  registered copy of owner adr
//  s_sel        out  SEL_W   registered copy of owner sel
//  s_dat_m      out  DATA_W  registered copy of owner dat_m
//  s_dat_s      in   DATA_W  read data from eviction cache
//  s_ack/s_rty  in   1       slave completion / retry
// BEHAVIOUR
//  Reset: state IDLE, prio=0 (m0 preferred), all outputs 0 incl. s_adr/s_sel/s_dat_m, m*_dat_s.
//  Request = m*_cyc & m*_stb. FSM IDLE -> BUSY -> RESP -> IDLE.
//  IDLE: no request: stay. One request: grant it. Both: grant prio master.
//    On grant: latch owner id; s_adr/s_sel/s_we/s_dat_m <= owner's; s_cyc=s_stb=1 next cycle; -> BUSY.
//  BUSY: hold s_* stable. s_ack: m_dat_s <= s_dat_s (reads only), -> RESP. s_rty: -> RESP w/ retry.
//    s_ack & s_rty same cycle: ack wins. s_cyc/s_stb drop on the same edge that enters RESP.
//  RESP: owner's m*_ack (or m*_rty) high exactly this cycle; other master sees 0; prio <= ~owner; -> IDLE.
//  Latency: grant edge N -> s_stb at N+1; s_ack at cycle M -> m*_ack at M+1. Min 3 cycles req->ack.
//  RESP->IDLE gap ensures a master that drops stb on ack is never re-served.
//  Losing master waits; no starvation: after each completion the other master is preferred.
//  Owner dropping cyc/stb in BUSY is illegal: cycle completes downstream, ack/rty still pulsed.
//  m*_dat_s holds last value between transactions; write completions do not update it.
//  rst in any state: next cycle IDLE, s_cyc/s_stb=0, no ack/rty issued, prio=0.
// CONFIGURATION
//  LINE_ARB_TIMEOUT_EN defined: 8-bit counter clears on BUSY entry, +1 each BUSY cycle;
//    reaching TIMEOUT without s_ack/s_rty -> drop s_cyc/s_stb, -> RESP with m*_rty; m*_dat_s unchanged.
//    Late s_ack/s_rty arriving after abort (in RESP/IDLE) is ignored.
//  Undefined: no counter; BUSY waits indefinitely for s_ack/s_rty.
// TESTING
//  m0 read adr=12'h123, s_ack+s_dat_s=128'hA5..A5 after 4 cycles -> s_adr=12'h123, m0_ack 1 cycle, m0_dat_s=A5..A5.
//  m0,m1 request same cycle after reset -> m0 first; m1 granted next; third simultaneous pair -> m0 again.
//  m1 write adr=12'hFFF sel=16'h00F0 -> s_we=1, s_sel=16'h00F0, s_dat_m matches; m1_ack; m1_dat_s unchanged.
//  s_rty during m0 read -> m0_rty 1 cycle, m0_ack=0; m0 reissues -> served normally.
//  rst asserted in BUSY -> next cycle s_stb=0, no m*_ack; following request from m1 granted only after m0 prio.
//  With LINE_ARB_TIMEOUT_EN, no s_ack for 255 cycles -> s_stb drops, m0_rty pulses; late s_ack ignored.

Source files
------------

// File: rtl/line_arbiter_wb.sv
// Two-master round-robin Wishbone line arbiter in front of the write-back cache slave port.
// Optional watchdog abort of stalled slave cycles: define LINE_ARB_TIMEOUT_EN.
module line_arbiter_wb #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 128,
  parameter int SEL_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc,
  input  logic              m0_stb,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_adr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_dat_m,
  output logic [DATA_W-1:0] m0_dat_s,
  output logic              m0_ack,
  output logic              m0_rty,
  input  logic              m1_cyc,
  input  logic              m1_stb,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_adr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_dat_m,
  output logic [DATA_W-1:0] m1_dat_s,
  output logic              m1_ack,
  output logic              m1_rty,
  output logic              s_cyc,
  output logic              s_stb,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_adr,
  output logic [SEL_W-1:0]  s_sel,
  output logic [DATA_W-1:0] s_dat_m,
  input  logic [DATA_W-1:0] s_dat_s,
  input  logic              s_ack,
  input  logic              s_rty
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;
  logic owner_r, prio_r;
  logic req0_s, req1_s;
  logic grant_s, grant_id_s;
  logic fin_ack_s, fin_rty_s;
  logic timeout_hit_s;
  logic              own_we_s;
  logic [ADDR_W-1:0] own_adr_s;
  logic [SEL_W-1:0]  own_sel_s;
  logic [DATA_W-1:0] own_dat_s;

  assign req0_s = m0_cyc & m0_stb;
  assign req1_s = m1_cyc & m1_stb;

`ifdef LINE_ARB_TIMEOUT_EN
  logic [7:0] cnt_r;

  // Watchdog: counts BUSY cycles since the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if (grant_s) begin
      cnt_r <= 8'd0;
    end else if (state_r == ST_BUSY) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Fires on the TIMEOUT-th BUSY cycle without a slave response
  assign timeout_hit_s = (state_r == ST_BUSY) && (cnt_r == 8'(TIMEOUT - 1));
`else
  logic unused_timeout_s;
  assign timeout_hit_s    = 1'b0;
  assign unused_timeout_s = ^8'(TIMEOUT);
`endif

  // Next-state and grant/completion decode
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_id_s  = owner_r;
    fin_ack_s   = 1'b0;
    fin_rty_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0_s && req1_s) begin
          grant_s     = 1'b1;
          grant_id_s  = prio_r;
          state_nxt_s = ST_BUSY;
        end else if (req0_s) begin
          grant_s     = 1'b1;
          grant_id_s  = 1'b0;
          state_nxt_s = ST_BUSY;
        end else if (req1_s) begin
          grant_s     = 1'b1;
          grant_id_s  = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Ack takes precedence over retry and over a coincident watchdog expiry
        if (s_ack) begin
          fin_ack_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (s_rty || timeout_hit_s) begin
          fin_rty_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Selects the request fields of the master being granted
  always_comb begin
    if (grant_id_s) begin
      own_we_s  = m1_we;
      own_adr_s = m1_adr;
      own_sel_s = m1_sel;
      own_dat_s = m1_dat_m;
    end else begin
      own_we_s  = m0_we;
      own_adr_s = m0_adr;
      own_sel_s = m0_sel;
      own_dat_s = m0_dat_m;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Ownership, priority, slave strobes and master response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
      s_cyc   <= 1'b0;
      s_stb   <= 1'b0;
      m0_ack  <= 1'b0;
      m1_ack  <= 1'b0;
      m0_rty  <= 1'b0;
      m1_rty  <= 1'b0;
    end else begin
      if (grant_s) begin
        owner_r <= grant_id_s;
        s_cyc   <= 1'b1;
        s_stb   <= 1'b1;
      end else if (fin_ack_s || fin_rty_s) begin
        s_cyc   <= 1'b0;
        s_stb   <= 1'b0;
      end
      m0_ack <= fin_ack_s & ~owner_r;
      m1_ack <= fin_ack_s &  owner_r;
      m0_rty <= fin_rty_s & ~owner_r;
      m1_rty <= fin_rty_s &  owner_r;
      // The master just served yields priority to the other one
      if (state_r == ST_RESP) begin
        prio_r <= ~owner_r;
      end
    end
  end

  // Slave request copy and per-master read data holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s_we     <= 1'b0;
      s_adr    <= '0;
      s_sel    <= '0;
      s_dat_m  <= '0;
      m0_dat_s <= '0;
      m1_dat_s <= '0;
    end else begin
      if (grant_s) begin
        s_we    <= own_we_s;
        s_adr   <= own_adr_s;
        s_sel   <= own_sel_s;
        s_dat_m <= own_dat_s;
      end
      if (fin_ack_s && !s_we) begin
        if (owner_r) begin
          m1_dat_s <= s_dat_s;
        end else begin
          m0_dat_s <= s_dat_s;
        end
      end
    end
  end

endmodule
